// File: rtl/stack_ptr_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stack_ptr_unit_pkg
// Purpose  : Shared constants and FSM state encoding for the stack-pointer
//            unit (SFR address, reset SP, ram_sel stack codes, state enum).
// Revision : 1.0  initial release
// ============================================================================
package stack_ptr_unit_pkg;

  // SFR address of SP and its reset value
  localparam logic [7:0] SFR_SP = 8'h81;
  localparam logic [7:0] RST_SP = 8'h07;

  // ram_sel codes that select a single-byte stack access
  localparam logic [3:0] WR_RAM_STACK = 4'h2;
  localparam logic [3:0] RD_RAM_STACK = 4'h3;

  // CALL/RET sequencer state encoding
  typedef enum logic [2:0] {
    SP_ST_IDLE    = 3'd0,
    SP_ST_PUSH_LO = 3'd1,
    SP_ST_PUSH_HI = 3'd2,
    SP_ST_POP_HI  = 3'd3,
    SP_ST_POP_LO  = 3'd4
  } sp_state_e;

endpackage : stack_ptr_unit_pkg
`default_nettype wire

// File: rtl/stack_ptr_unit_sp_seq_fsm.sv
`default_nettype none
// ============================================================================
// Module   : sp_seq_fsm
// Purpose  : CALL/RET sequencer. Steps through two push states (PC low then
//            high) or two pop states (PC high then low), one stack step per
//            state. An abort (SFR write to SP) returns it to IDLE at once.
// Revision : 1.0  initial release
// ============================================================================
module sp_seq_fsm
  import stack_ptr_unit_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic i_start_call,
  input  logic i_start_ret,
  input  logic i_abort,
  output logic o_step_push,
  output logic o_step_pop,
  output logic o_byte_hi,
  output logic o_busy
);

  sp_state_e r_state;
  sp_state_e w_next;

  // State register, asynchronously reset to IDLE
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= SP_ST_IDLE;
    else       r_state <= w_next;
  end

  // Next-state and per-state step/byte outputs
  always_comb begin
    w_next      = r_state;
    o_step_push = 1'b0;
    o_step_pop  = 1'b0;
    o_byte_hi   = 1'b0;
    o_busy      = 1'b1;
    case (r_state)
      SP_ST_IDLE: begin
        o_busy = 1'b0;
        if (i_start_call)     w_next = SP_ST_PUSH_LO;
        else if (i_start_ret) w_next = SP_ST_POP_HI;
      end
      SP_ST_PUSH_LO: begin
        o_step_push = 1'b1;
        w_next      = SP_ST_PUSH_HI;
      end
      SP_ST_PUSH_HI: begin
        o_step_push = 1'b1;
        o_byte_hi   = 1'b1;
        w_next      = SP_ST_IDLE;
      end
      SP_ST_POP_HI: begin
        o_step_pop = 1'b1;
        o_byte_hi  = 1'b1;
        w_next     = SP_ST_POP_LO;
      end
      SP_ST_POP_LO: begin
        o_step_pop = 1'b1;
        w_next     = SP_ST_IDLE;
      end
      default: begin
        o_busy = 1'b0;
        w_next = SP_ST_IDLE;
      end
    endcase
    // SP write aborts any sequence in progress
    if (i_abort) w_next = SP_ST_IDLE;
  end

endmodule : sp_seq_fsm
`default_nettype wire

// File: rtl/stack_ptr_unit.sv
`default_nettype none
// ============================================================================
// Module   : stack_ptr_unit
// Purpose  : 8051 stack-pointer unit. Holds SP, applies SFR writes, single
//            PUSH/POP via ram_sel and sequenced two-byte CALL/RET, and drives
//            the internal-RAM stack address and read/write strobes.
//            Optional macro SP_BOUNDS_CHECK_EN: block pushes at SP==LIMIT and
//            raise the sticky ovf flag; otherwise pushes wrap and ovf is 0.
// Revision : 1.0  initial release
// ============================================================================
module stack_ptr_unit
  import stack_ptr_unit_pkg::*;
#(
  parameter int               ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RST_VAL = ADDR_W'(RST_SP),
  parameter logic [ADDR_W-1:0] LIMIT   = {ADDR_W{1'b1}},
  parameter logic [7:0]        SFR_ADDR = SFR_SP
)(
  input  logic              clock,
  input  logic              reset,
  input  logic              i_wr,
  input  logic              i_wr_bit,
  input  logic [7:0]        i_wr_addr,
  input  logic [ADDR_W-1:0] i_wr_data,
  input  logic [3:0]        i_ram_sel,
  input  logic              i_call_req,
  input  logic              i_ret_req,
  output logic [ADDR_W-1:0] o_sp_out,
  output logic [ADDR_W-1:0] o_stack_addr,
  output logic              o_stack_we,
  output logic              o_stack_re,
  output logic              o_byte_hi,
  output logic              o_busy,
  output logic              o_ovf,
  output logic              o_udf
);

`ifdef SP_BOUNDS_CHECK_EN
  localparam bit c_BOUNDS_EN = 1'b1;
`else
  localparam bit c_BOUNDS_EN = 1'b0;
`endif

  logic [ADDR_W-1:0] r_sp;
  logic              r_ovf;
  logic              r_udf;

  logic w_sfr_wr;
  logic w_sel_push;
  logic w_sel_pop;
  logic w_single_push;
  logic w_single_pop;
  logic w_start_call;
  logic w_start_ret;
  logic w_fsm_push;
  logic w_fsm_pop;
  logic w_fsm_busy;
  logic w_push_step;
  logic w_pop_step;
  logic w_above_floor;
  logic w_at_limit;
  logic w_push_ok;
  logic w_pop_ok;
  logic w_ovf_evt;
  logic w_udf_evt;
  logic [ADDR_W-1:0] w_sp_inc;

  // Request decode: SFR write wins, then ram_sel, then call, then ret
  assign w_sfr_wr      = i_wr & ~i_wr_bit & (i_wr_addr == SFR_ADDR);
  assign w_sel_push    = (i_ram_sel == WR_RAM_STACK);
  assign w_sel_pop     = (i_ram_sel == RD_RAM_STACK);
  assign w_single_push = ~w_fsm_busy & ~w_sfr_wr & w_sel_push;
  assign w_single_pop  = ~w_fsm_busy & ~w_sfr_wr & w_sel_pop;
  assign w_start_call  = ~w_fsm_busy & ~w_sfr_wr & ~w_sel_push & ~w_sel_pop & i_call_req;
  assign w_start_ret   = ~w_fsm_busy & ~w_sfr_wr & ~w_sel_push & ~w_sel_pop &
                         ~i_call_req & i_ret_req;

  sp_seq_fsm u_seq (
    .clock        (clock),
    .reset        (reset),
    .i_start_call (w_start_call),
    .i_start_ret  (w_start_ret),
    .i_abort      (w_sfr_wr),
    .o_step_push  (w_fsm_push),
    .o_step_pop   (w_fsm_pop),
    .o_byte_hi    (o_byte_hi),
    .o_busy       (w_fsm_busy)
  );

  // An SP write in a busy cycle drops that cycle's sequencer step
  assign w_push_step   = (w_single_push | w_fsm_push) & ~w_sfr_wr;
  assign w_pop_step    = (w_single_pop  | w_fsm_pop)  & ~w_sfr_wr;

  assign w_sp_inc      = r_sp + 1'b1;
  assign w_above_floor = (r_sp > RST_VAL);
  assign w_at_limit    = c_BOUNDS_EN & (r_sp == LIMIT);

  assign w_push_ok     = w_push_step & ~w_at_limit;
  assign w_ovf_evt     = w_push_step &  w_at_limit;
  assign w_pop_ok      = w_pop_step  &  w_above_floor;
  assign w_udf_evt     = w_pop_step  & ~w_above_floor;

  // Push addresses the slot above SP; pop (and idle) addresses SP itself
  assign o_stack_addr  = w_push_step ? w_sp_inc : r_sp;
  assign o_stack_we    = w_push_ok;
  assign o_stack_re    = w_pop_ok;
  assign o_sp_out      = r_sp;
  assign o_busy        = w_fsm_busy;
  assign o_ovf         = r_ovf;
  assign o_udf         = r_udf;

  // SP register: SFR write overrides any stack step
  always_ff @(posedge clock or posedge reset) begin
    if (reset)          r_sp <= RST_VAL;
    else if (w_sfr_wr)  r_sp <= i_wr_data;
    else if (w_push_ok) r_sp <= w_sp_inc;
    else if (w_pop_ok)  r_sp <= r_sp - 1'b1;
  end

  // Sticky overflow/underflow flags, cleared by an SP write
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else if (w_sfr_wr) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      if (w_ovf_evt) r_ovf <= 1'b1;
      if (w_udf_evt) r_udf <= 1'b1;
    end
  end

endmodule : stack_ptr_unit
`default_nettype wire

// File: tb/tb_stack_ptr_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_stack_ptr_unit
// Purpose  : Directed self-checking bench for stack_ptr_unit.
// Revision : 1.0  initial release
// ============================================================================
module tb_stack_ptr_unit;
  import stack_ptr_unit_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic       wr, wr_bit;
  logic [7:0] wr_addr, wr_data;
  logic [3:0] ram_sel;
  logic       call_req, ret_req;
  logic [7:0] sp_out, stack_addr;
  logic       stack_we, stack_re, byte_hi, busy, ovf, udf;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  stack_ptr_unit dut (
    .clock        (clock),
    .reset        (reset),
    .i_wr         (wr),
    .i_wr_bit     (wr_bit),
    .i_wr_addr    (wr_addr),
    .i_wr_data    (wr_data),
    .i_ram_sel    (ram_sel),
    .i_call_req   (call_req),
    .i_ret_req    (ret_req),
    .o_sp_out     (sp_out),
    .o_stack_addr (stack_addr),
    .o_stack_we   (stack_we),
    .o_stack_re   (stack_re),
    .o_byte_hi    (byte_hi),
    .o_busy       (busy),
    .o_ovf        (ovf),
    .o_udf        (udf)
  );

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs;
    wr = 0; wr_bit = 0; wr_addr = 8'h00; wr_data = 8'h00;
    ram_sel = 4'h0; call_req = 0; ret_req = 0;
  endtask

  task automatic sfr_write(input logic [7:0] d);
    idle_inputs();
    wr = 1; wr_addr = SFR_SP; wr_data = d;
    tick();
    idle_inputs();
  endtask

  task automatic test_reset;
    idle_inputs();
    reset = 1;
    tick(); tick();
    reset = 0;
    #1;
    n_cmp++; if ({sp_out, busy, ovf, udf, stack_we, stack_re} !== {8'h07, 5'b0}) begin
      n_bad++; $display("FAIL reset_state: sp=%h busy=%b ovf=%b udf=%b we=%b re=%b expected sp=07 rest 0",
                        sp_out, busy, ovf, udf, stack_we, stack_re);
    end
    // Reset asserted in the middle of a CALL
    sfr_write(8'h30);
    call_req = 1; tick(); idle_inputs();
    tick();
    n_cmp++; if (sp_out !== 8'h31 || busy !== 1'b1) begin
      n_bad++; $display("FAIL reset_precall: sp=%h busy=%b expected 31/1", sp_out, busy);
    end
    #1 reset = 1;
    #1;
    n_cmp++; if ({sp_out, busy, ovf, udf} !== {8'h07, 3'b0}) begin
      n_bad++; $display("FAIL reset_midcall: sp=%h busy=%b ovf=%b udf=%b expected 07/0/0/0",
                        sp_out, busy, ovf, udf);
    end
    tick();
    reset = 0;
    #1;
  endtask

  task automatic test_single_push;
    logic [7:0] exp_a [3];
    exp_a[0] = 8'h08; exp_a[1] = 8'h09; exp_a[2] = 8'h0A;
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      ram_sel = WR_RAM_STACK;
      #1;
      n_cmp++; if (stack_addr !== exp_a[i] || stack_we !== 1'b1) begin
        n_bad++; $display("FAIL push_%0d: addr=%h we=%b expected %h/1", i, stack_addr, stack_we, exp_a[i]);
      end
      tick();
    end
    idle_inputs();
    n_cmp++; if (sp_out !== 8'h0A) begin
      n_bad++; $display("FAIL push_sp: sp=%h expected 0a", sp_out);
    end
  endtask

  task automatic test_single_pop;
    idle_inputs();
    ram_sel = RD_RAM_STACK;
    #1;
    n_cmp++; if (stack_addr !== 8'h0A || stack_re !== 1'b1 || stack_we !== 1'b0) begin
      n_bad++; $display("FAIL pop_strobe: addr=%h re=%b we=%b expected 0a/1/0", stack_addr, stack_re, stack_we);
    end
    tick(); idle_inputs();
    n_cmp++; if (sp_out !== 8'h09) begin
      n_bad++; $display("FAIL pop_sp: sp=%h expected 09", sp_out);
    end
  endtask

  task automatic test_call;
    sfr_write(8'h20);
    call_req = 1; tick(); idle_inputs();
    #1;
    n_cmp++; if ({stack_addr, stack_we, byte_hi, busy} !== {8'h21, 1'b1, 1'b0, 1'b1}) begin
      n_bad++; $display("FAIL call_c1: addr=%h we=%b hi=%b busy=%b expected 21/1/0/1",
                        stack_addr, stack_we, byte_hi, busy);
    end
    // A ram_sel pop while busy is ignored
    ram_sel = RD_RAM_STACK;
    tick(); idle_inputs();
    n_cmp++; if ({stack_addr, stack_we, stack_re, byte_hi} !== {8'h22, 1'b1, 1'b0, 1'b1}) begin
      n_bad++; $display("FAIL call_c2: addr=%h we=%b re=%b hi=%b expected 22/1/0/1",
                        stack_addr, stack_we, stack_re, byte_hi);
    end
    tick();
    n_cmp++; if (sp_out !== 8'h22 || busy !== 1'b0) begin
      n_bad++; $display("FAIL call_end: sp=%h busy=%b expected 22/0", sp_out, busy);
    end
  endtask

  task automatic test_ret_floor;
    sfr_write(8'h08);
    ret_req = 1; tick(); idle_inputs();
    n_cmp++; if ({stack_addr, stack_re, byte_hi} !== {8'h08, 1'b1, 1'b1}) begin
      n_bad++; $display("FAIL ret_hi: addr=%h re=%b hi=%b expected 08/1/1", stack_addr, stack_re, byte_hi);
    end
    tick();
    n_cmp++; if ({sp_out, stack_re, byte_hi, busy} !== {8'h07, 1'b0, 1'b0, 1'b1}) begin
      n_bad++; $display("FAIL ret_lo: sp=%h re=%b hi=%b busy=%b expected 07/0/0/1",
                        sp_out, stack_re, byte_hi, busy);
    end
    tick();
    n_cmp++; if ({sp_out, udf, busy} !== {8'h07, 1'b1, 1'b0}) begin
      n_bad++; $display("FAIL ret_end: sp=%h udf=%b busy=%b expected 07/1/0", sp_out, udf, busy);
    end
  endtask

  task automatic test_sfr_priority;
    // SP write together with a push: push dropped, udf cleared
    idle_inputs();
    wr = 1; wr_addr = SFR_SP; wr_data = 8'h50; ram_sel = WR_RAM_STACK;
    #1;
    n_cmp++; if (stack_we !== 1'b0) begin
      n_bad++; $display("FAIL sfr_push_we: we=%b expected 0", stack_we);
    end
    tick(); idle_inputs();
    n_cmp++; if ({sp_out, udf, ovf} !== {8'h50, 2'b00}) begin
      n_bad++; $display("FAIL sfr_push_sp: sp=%h udf=%b ovf=%b expected 50/0/0", sp_out, udf, ovf);
    end
    // Bit-addressed write must not touch SP
    wr = 1; wr_bit = 1; wr_addr = SFR_SP; wr_data = 8'h99;
    tick(); idle_inputs();
    n_cmp++; if (sp_out !== 8'h50) begin
      n_bad++; $display("FAIL sfr_bitwr: sp=%h expected 50", sp_out);
    end
    // SP write during PUSH_HI aborts the CALL
    call_req = 1; tick(); idle_inputs();
    tick();
    wr = 1; wr_addr = SFR_SP; wr_data = 8'h50;
    #1;
    n_cmp++; if (stack_we !== 1'b0 || byte_hi !== 1'b1) begin
      n_bad++; $display("FAIL sfr_abort_we: we=%b hi=%b expected 0/1", stack_we, byte_hi);
    end
    tick(); idle_inputs();
    tick();
    n_cmp++; if ({sp_out, busy, ovf, udf} !== {8'h50, 3'b0}) begin
      n_bad++; $display("FAIL sfr_abort_end: sp=%h busy=%b ovf=%b udf=%b expected 50/0/0/0",
                        sp_out, busy, ovf, udf);
    end
  endtask

  task automatic test_limit;
    logic [7:0] exp_sp;
    logic       exp_we, exp_ovf;
`ifdef SP_BOUNDS_CHECK_EN
    exp_sp = 8'hFF; exp_we = 1'b0; exp_ovf = 1'b1;
`else
    exp_sp = 8'h00; exp_we = 1'b1; exp_ovf = 1'b0;
`endif
    sfr_write(8'hFF);
    ram_sel = WR_RAM_STACK;
    #1;
    n_cmp++; if (stack_we !== exp_we) begin
      n_bad++; $display("FAIL limit_we: we=%b expected %b", stack_we, exp_we);
    end
    tick(); idle_inputs();
    n_cmp++; if (sp_out !== exp_sp || ovf !== exp_ovf) begin
      n_bad++; $display("FAIL limit_sp: sp=%h ovf=%b expected %h/%b", sp_out, ovf, exp_sp, exp_ovf);
    end
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    test_reset();
    test_single_push();
    test_single_pop();
    test_call();
    test_ret_floor();
    test_sfr_priority();
    test_limit();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_stack_ptr_unit
`default_nettype wire
